// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts out one odd-parity frame on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       keyclk_in,
  input  logic       keydata_in,
  output logic       keyclk_oe,
  output logic       keydata_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             ack_ok_q, ack_ok_d;
  logic             keyclk_oe_q, keyclk_oe_d;
  logic             keydata_oe_q, keydata_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;

  logic clk_meta, clk_s, clk_s_prev;
  logic dat_meta, dat_s;
  logic fall;
  logic timeout;

  // Synchronisers idle high so reset release never fakes a clock fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta   <= 1'b1;
      clk_s      <= 1'b1;
      clk_s_prev <= 1'b1;
      dat_meta   <= 1'b1;
      dat_s      <= 1'b1;
    end else begin
      clk_meta   <= keyclk_in;
      clk_s      <= clk_meta;
      clk_s_prev <= clk_s;
      dat_meta   <= keydata_in;
      dat_s      <= dat_meta;
    end
  end

  assign fall    = clk_s_prev & ~clk_s;
  assign timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      inh_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      bit_idx_q    <= '0;
      frame_q      <= '0;
      ack_ok_q     <= 1'b0;
      keyclk_oe_q  <= 1'b0;
      keydata_oe_q <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inh_cnt_q    <= inh_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bit_idx_q    <= bit_idx_d;
      frame_q      <= frame_d;
      ack_ok_q     <= ack_ok_d;
      keyclk_oe_q  <= keyclk_oe_d;
      keydata_oe_q <= keydata_oe_d;
      tx_done_q    <= tx_done_d;
      tx_error_q   <= tx_error_d;
    end
  end

  // Line enables are computed for the next state and registered, so each
  // state sees its own oe values from its first cycle.
  always_comb begin
    state_d      = state_q;
    inh_cnt_d    = inh_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    bit_idx_d    = bit_idx_q;
    frame_d      = frame_q;
    ack_ok_d     = ack_ok_q;
    keyclk_oe_d  = keyclk_oe_q;
    keydata_oe_d = keydata_oe_q;
    tx_done_d    = 1'b0;
    tx_error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        keyclk_oe_d  = 1'b0;
        keydata_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d     = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d   = '0;
          keyclk_oe_d = 1'b1;
          state_d     = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        keyclk_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          keydata_oe_d = 1'b1;
          state_d      = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      S_REQ: begin
        keyclk_oe_d  = 1'b0;
        keydata_oe_d = 1'b1;
        bit_idx_d    = '0;
        tmo_cnt_d    = '0;
        state_d      = S_BITS;
      end

      S_BITS: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (timeout) begin
          keyclk_oe_d  = 1'b0;
          keydata_oe_d = 1'b0;
          tx_error_d   = 1'b1;
          state_d      = S_IDLE;
        end else if (fall) begin
          keydata_oe_d = ~frame_q[bit_idx_q];
          bit_idx_d    = (bit_idx_q == 4'hF) ? bit_idx_q : bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end

      S_ACK: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (timeout) begin
          keyclk_oe_d  = 1'b0;
          keydata_oe_d = 1'b0;
          tx_error_d   = 1'b1;
          state_d      = S_IDLE;
        end else if (fall) begin
          ack_ok_d = ~dat_s;
          state_d  = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (timeout) begin
          keyclk_oe_d  = 1'b0;
          keydata_oe_d = 1'b0;
          tx_error_d   = 1'b1;
          state_d      = S_IDLE;
        end else if (clk_s && dat_s) begin
          keyclk_oe_d  = 1'b0;
          keydata_oe_d = 1'b0;
          tx_done_d    = ack_ok_q;
          tx_error_d   = ~ack_ok_q;
          state_d      = S_IDLE;
        end
      end

      default: begin
        keyclk_oe_d  = 1'b0;
        keydata_oe_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  assign keyclk_oe  = keyclk_oe_q;
  assign keydata_oe = keydata_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines captures each frame,
// and a scoreboard checks outcomes, bus timing and handshake invariants every cycle.
module tb_ps2_host_tx;

  localparam int unsigned INH    = 50;
  localparam int unsigned TMO    = 2000;
  localparam int          BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       keyclk_oe, keydata_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       keyclk_line, keydata_line;

  assign keyclk_line  = dev_clk & ~keyclk_oe;
  assign keydata_line = dev_dat & ~keydata_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .keyclk_in (keyclk_line),
    .keydata_in(keydata_line),
    .keyclk_oe (keyclk_oe),
    .keydata_oe(keydata_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   exp_q[$];  // 1 = tx_done expected, 0 = tx_error expected
  int   t_inh = 0, t_req = 0, t_err = 0;
  logic kclk_prev = 1'b0, req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] v);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(v[i]);
    return (ones % 2) == 0;
  endfunction

  // Per-cycle monitor: invariants, inhibit length and outcome scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_busy_excl", 32'(tx_ready ^ busy), 1);
      check("done_err_excl", 32'(tx_done & tx_error), 0);
      if (keyclk_oe && !kclk_prev) t_inh = cyc;
      if (keyclk_oe && keydata_oe && !req_prev) begin
        t_req = cyc;
        check("inhibit_len", t_req - t_inh, INH);
      end
      if (tx_done || tx_error) begin
        check("idle_on_pulse", 32'({keyclk_oe, keydata_oe, tx_ready}), 32'b001);
        if (tx_error) t_err = cyc;
        if (exp_q.size() == 0) check("unexpected_pulse", 32'({tx_done, tx_error}), 0);
        else check("outcome_done", 32'(tx_done), 32'(exp_q.pop_front()));
      end
    end
    kclk_prev = keyclk_oe;
    req_prev  = keyclk_oe & keydata_oe;
  end

  task automatic send(input logic [7:0] d);
    int i = 0;
    while (!tx_ready && i < BUDGET) begin @(negedge clk); i++; end
    check("send_ready", 32'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    @(negedge clk);
    while (busy && i < BUDGET) begin @(negedge clk); i++; end
    check("idle_reached", 32'(busy), 0);
    repeat (2) @(negedge clk);
    check("pulses_seen", exp_q.size(), 0);
    check("ready_after", 32'(tx_ready), 1);
  endtask

  // Device side: waits for inhibit and start, then clocks the frame in.
  task automatic device(input bit ack, input int half, input int abort_at,
                        output logic [7:0] d, output logic par, output logic stp);
    logic [9:0] bits = '0;
    int i = 0;
    d = '0; par = 1'b0; stp = 1'b0;
    while (keyclk_line !== 1'b0 && i < BUDGET) begin @(negedge clk); i++; end
    check("dev_saw_inhibit", 32'(keyclk_line), 0);
    i = 0;
    while (!(keyclk_line === 1'b1 && keydata_line === 1'b0) && i < BUDGET) begin
      @(negedge clk); i++;
    end
    check("dev_saw_start", 32'({keyclk_line, keydata_line}), 32'b10);
    repeat (half) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (k == abort_at) return;
      dev_clk = 1'b1;
      @(negedge clk);
      bits[k-1] = keydata_line;
      repeat (half - 1) @(negedge clk);
    end
    if (ack) dev_dat = 1'b0;
    repeat (half / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (half) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_dat = 1'b1;
    d   = bits[7:0];
    par = bits[8];
    stp = bits[9];
  endtask

  task automatic do_frame(input logic [7:0] d, input bit ack, input int half,
                          input string tag, output logic cp);
    logic [7:0] cd;
    logic       cs;
    exp_q.push_back(ack);
    fork
      send(d);
      device(ack, half, 0, cd, cp, cs);
    join
    wait_idle();
    check({tag, "_data"}, 32'(cd), 32'(d));
    check({tag, "_parity"}, 32'(cp), 32'(odd_par(d)));
    check({tag, "_stop"}, 32'(cs), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic       p, p2, c2;
    logic [7:0] cd, cd2, rd;
    bit         rack;

    repeat (2) @(negedge clk);
    check("rst_oe", 32'({keyclk_oe, keydata_oe}), 0);
    check("rst_ready_busy", 32'({tx_ready, busy}), 32'b10);
    check("rst_pulses", 32'({tx_done, tx_error}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Set-LEDs command with ACK; 0xED has six ones so parity is 1
    do_frame(8'hED, 1'b1, 20, "ed", p);
    check("ed_par_literal", 32'(p), 1);

    // Back-to-back 0x01 then 0xFF
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    fork
      begin send(8'h01); send(8'hFF); end
      begin
        device(1'b1, 12, 0, cd, p, c2);
        device(1'b1, 12, 0, cd2, p2, c2);
      end
    join
    wait_idle();
    check("b2b_first", 32'(cd), 32'h01);
    check("b2b_first_par", 32'(p), 0);
    check("b2b_second", 32'(cd2), 32'hFF);
    check("b2b_second_par", 32'(p2), 1);

    // NACK
    do_frame(8'hF4, 1'b0, 15, "nack", p);
    check("nack_par_literal", 32'(p), 0);

    // No device clocks: timeout measured from the end of REQ
    exp_q.push_back(1'b0);
    send(8'hAA);
    wait_idle();
    check("timeout_latency", t_err - (t_req + 1), TMO);
    check("timeout_oe", 32'({keyclk_oe, keydata_oe}), 0);

    // Reset after 4th fall of 0x55: d3=0 is being driven, so keydata_oe=1
    fork
      send(8'h55);
      device(1'b1, 16, 4, cd, p, c2);
    join
    check("mid_frame_d3", 32'(keydata_oe), 1);
    #1 rst = 1'b0;
    #1 check("async_rst_oe", 32'({keyclk_oe, keydata_oe}), 0);
    check("async_rst_ready", 32'(tx_ready), 1);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(tx_ready), 1);
    do_frame(8'h12, 1'b1, 10, "after_rst", p);

    // tx_valid with 0x33 while busy with 0xED must be ignored
    exp_q.push_back(1'b1);
    fork
      send(8'hED);
      device(1'b1, 18, 0, cd, p, c2);
      begin
        repeat (INH + 20) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h33;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
      end
    join
    wait_idle();
    check("ignore_busy_data", 32'(cd), 32'hED);

    // Randomized frames, random ACK/NACK and device clock rate
    for (int n = 0; n < 8; n++) begin
      rd   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      do_frame(rd, rack, int'($urandom_range(6, 25)), "rand", p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
